bs_select_scheduler: RTL and testbench



---
 rtl/bs_select_scheduler.sv | 145 ++++++++++++++
 tb/tb_bs_select_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_select_scheduler.sv
// Double-banked time-slot scheduler for the bitstream crossbar select bus.
// The host fills the shadow bank; the banks swap only at a schedule boundary.
module bs_select_scheduler #(
   parameter int BS        = 8,
   parameter int NUM_BS    = 256,
   parameter int NUM_SLOTS = 16,
   localparam int SEL_W    = $clog2(NUM_BS),
   localparam int SLOT_W   = $clog2(NUM_SLOTS),
   localparam int LANE_W   = $clog2(BS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [SLOT_W-1:0]   cfg_slot,
   input  logic [LANE_W-1:0]   cfg_lane,
   input  logic [SEL_W-1:0]    cfg_sel,
   input  logic                cfg_commit,
   input  logic [SLOT_W:0]     cfg_len,
   input  logic                start,
   input  logic                stop,
   input  logic                tick,
   output logic [SEL_W*BS-1:0] bs_select,
   output logic [SLOT_W-1:0]   slot,
   output logic                running,
   output logic                commit_pending,
   output logic                swap_done,
   output logic                err
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   localparam logic [SLOT_W:0] MAX_LEN = (SLOT_W+1)'(NUM_SLOTS);

   state_t state, state_nx;

   logic [SEL_W-1:0] mem [2][NUM_SLOTS][BS];
   logic             bank;
   logic [SLOT_W:0]  active_len;
   logic [SLOT_W:0]  shadow_len;

   logic              adv;
   logic              wrap;
   logic              swap;
   logic              wr_en;
   logic              len_ok;
   logic              commit_ok;
   logic              bank_nx;
   logic [SLOT_W-1:0] slot_nx;
   logic [SEL_W*BS-1:0] sel_nx;

   assign cfg_ready = !commit_pending;
   assign running   = (state != IDLE);
   assign wr_en     = cfg_valid && cfg_ready;
   assign len_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN);
   assign commit_ok = cfg_commit && len_ok && !commit_pending;

   assign adv  = tick && (state != IDLE);
   assign wrap = adv && ({1'b0, slot} == active_len - 1'b1);
   // An idle block has no boundary to wait for, so a pending swap lands at once.
   assign swap = commit_pending && ((state == IDLE) || wrap);

   assign bank_nx = swap ? !bank : bank;

   always_comb begin
      slot_nx = slot;
      if (swap || wrap) begin
         slot_nx = '0;
      end else if (adv) begin
         slot_nx = slot + 1'b1;
      end
   end

   // The bank being read is never the one being written on the same edge.
   always_comb begin
      sel_nx = '0;
      for (int i = 0; i < BS; i++) begin
         sel_nx[SEL_W*i +: SEL_W] = mem[bank_nx][slot_nx][i];
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start && !stop) state_nx = RUN;
         end
         RUN: begin
            if (stop) state_nx = wrap ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (start && !stop) state_nx = RUN;
            else if (wrap)      state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank           <= 1'b0;
         active_len     <= (SLOT_W+1)'(1);
         shadow_len     <= (SLOT_W+1)'(1);
         slot           <= '0;
         bs_select      <= '0;
         commit_pending <= 1'b0;
         swap_done      <= 1'b0;
         err            <= 1'b0;
      end else begin
         bank      <= bank_nx;
         slot      <= slot_nx;
         bs_select <= sel_nx;
         swap_done <= swap;
         err       <= cfg_commit && !commit_ok;
         if (commit_ok) begin
            shadow_len     <= cfg_len;
            commit_pending <= 1'b1;
         end else if (swap) begin
            commit_pending <= 1'b0;
         end
         if (swap) active_len <= shadow_len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int s = 0; s < NUM_SLOTS; s++)
               for (int l = 0; l < BS; l++)
                  mem[b][s][l] <= '0;
      end else if (wr_en) begin
         mem[!bank][cfg_slot][cfg_lane] <= cfg_sel;
      end
   end

endmodule

// File: tb/tb_bs_select_scheduler.sv
// Randomised and directed bench for bs_select_scheduler against a
// schedule-level model of banks, pass position and pending swap.
module tb_bs_select_scheduler;

   localparam int BS = 8;
   localparam int NS = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [3:0]  cfg_slot = '0;
   logic [2:0]  cfg_lane = '0;
   logic [7:0]  cfg_sel = '0;
   logic        cfg_commit = 1'b0;
   logic [4:0]  cfg_len = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        tick = 1'b0;
   logic [63:0] bs_select;
   logic [3:0]  slot;
   logic        running;
   logic        commit_pending;
   logic        swap_done;
   logic        err;

   bs_select_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_slot(cfg_slot), .cfg_lane(cfg_lane), .cfg_sel(cfg_sel),
      .cfg_commit(cfg_commit), .cfg_len(cfg_len),
      .start(start), .stop(stop), .tick(tick),
      .bs_select(bs_select), .slot(slot), .running(running),
      .commit_pending(commit_pending), .swap_done(swap_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Model: schedule tables, which one is live, where the pass is.
   int m_mem [2][NS][BS];
   int m_live;
   int m_alen;
   int m_slen;
   int m_pos;
   bit m_pend;
   bit m_active;
   bit m_draining;
   bit m_err;
   bit m_sd;

   task automatic model_reset();
      foreach (m_mem[b, s, l]) m_mem[b][s][l] = 0;
      m_live = 0; m_alen = 1; m_slen = 1; m_pos = 0;
      m_pend = 0; m_active = 0; m_draining = 0;
      m_err = 0; m_sd = 0;
   endtask

   task automatic model_edge(input bit v, input int cs, input int cl,
                             input int sel, input bit cm, input int len,
                             input bit st, input bit sp, input bit tk);
      bit was_pend, stepping, at_end, do_swap;
      was_pend = m_pend;
      stepping = tk && m_active;
      at_end   = stepping && (m_pos == m_alen - 1);
      do_swap  = was_pend && (!m_active || at_end);
      if (v && !was_pend) m_mem[1 - m_live][cs][cl] = sel;
      m_err = 0;
      if (cm) begin
         if (len >= 1 && len <= NS && !was_pend) begin
            m_slen = len;
            m_pend = 1;
         end else begin
            m_err = 1;
         end
      end
      if (!m_active) begin
         if (st && !sp) begin m_active = 1; m_draining = 0; end
      end else if (!m_draining) begin
         if (sp) begin
            if (at_end) m_active = 0;
            else m_draining = 1;
         end
      end else begin
         if (st && !sp) m_draining = 0;
         else if (at_end) begin m_active = 0; m_draining = 0; end
      end
      if (stepping) m_pos = at_end ? 0 : m_pos + 1;
      m_sd = do_swap;
      if (do_swap) begin
         m_live = 1 - m_live;
         m_alen = m_slen;
         m_pos  = 0;
         m_pend = 0;
      end
   endtask

   function automatic logic [63:0] m_select();
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < BS; i++) r[8*i +: 8] = 8'(m_mem[m_live][m_pos][i]);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("slot", 64'(slot), 64'(m_pos));
      check("bs_select", bs_select, m_select());
      check("running", 64'(running), 64'(m_active));
      check("commit_pending", 64'(commit_pending), 64'(m_pend));
      check("cfg_ready", 64'(cfg_ready), 64'(!m_pend));
      check("swap_done", 64'(swap_done), 64'(m_sd));
      check("err", 64'(err), 64'(m_err));
   endtask

   function automatic logic [7:0] lane(input int i);
      return bs_select[8*i +: 8];
   endfunction

   task automatic step(input bit v, input int cs, input int cl, input int sel,
                       input bit cm, input int len,
                       input bit st, input bit sp, input bit tk);
      cfg_valid = v; cfg_slot = 4'(cs); cfg_lane = 3'(cl); cfg_sel = 8'(sel);
      cfg_commit = cm; cfg_len = 5'(len);
      start = st; stop = sp; tick = tk;
      @(posedge clk);
      model_edge(v, cs, cl, sel, cm, len, st, sp, tk);
      #1;
      compare_all();
   endtask

   task automatic idle();       step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_tick();    step(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic wr(input int s, input int l, input int v);
      step(1, s, l, v, 0, 0, 0, 0, 0);
   endtask
   task automatic commit(input int len); step(0, 0, 0, 0, 1, len, 0, 0, 0); endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_bs_select", bs_select, 64'd0);
      check("rst_slot", 64'(slot), 64'd0);
      check("rst_running", 64'(running), 64'd0);
      check("rst_pending", 64'(commit_pending), 64'd0);
      check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
      idle();

      for (int s = 0; s < 4; s++)
         for (int l = 0; l < BS; l++) wr(s, l, 10 * s + l);
      commit(4);
      check("lit_pending_t1", 64'(commit_pending), 64'd1);
      idle();
      check("lit_swap_done_t2", 64'(swap_done), 64'd1);
      check("lit_lane0", 64'(lane(0)), 64'd0);
      check("lit_lane7", 64'(lane(7)), 64'd7);

      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("lit_running", 64'(running), 64'd1);
      begin
         int exp_l0 [6] = '{10, 20, 30, 0, 10, 20};
         for (int k = 0; k < 6; k++) begin
            do_tick();
            check("lit_tick_lane0", 64'(lane(0)), 64'(exp_l0[k]));
         end
      end

      for (int s = 0; s < 2; s++)
         for (int l = 0; l < BS; l++) wr(s, l, 255);
      do_tick(); do_tick(); do_tick();
      check("lit_slot1", 64'(slot), 64'd1);
      commit(2);
      check("lit_ready_low", 64'(cfg_ready), 64'd0);
      do_tick();
      check("lit_old_sched", 64'(lane(0)), 64'd20);
      do_tick();
      do_tick();
      check("lit_wrap_slot", 64'(slot), 64'd0);
      check("lit_wrap_lanes", bs_select, {8{8'd255}});
      check("lit_wrap_swap", 64'(swap_done), 64'd1);

      commit(0);
      check("lit_err_len0", 64'(err), 64'd1);
      idle();
      commit(17);
      check("lit_err_len17", 64'(err), 64'd1);
      commit(3);
      commit(4);
      check("lit_err_pending", 64'(err), 64'd1);
      do_tick(); do_tick();
      check("lit_len3_lane3", 64'(lane(3)), 64'd3);

      commit(4);
      do_tick(); do_tick(); do_tick();
      do_tick();
      check("lit_drain_slot1", 64'(slot), 64'd1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("lit_drain_running", 64'(running), 64'd1);
      do_tick(); do_tick(); do_tick();
      check("lit_idle_running", 64'(running), 64'd0);
      check("lit_idle_slot", 64'(slot), 64'd0);
      do_tick(); do_tick();
      check("lit_idle_ignored", 64'(slot), 64'd0);

      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      do_tick();
      commit(2);
      do_reset();
      idle();

      for (int k = 0; k < 4000; k++) begin
         step($urandom_range(1, 0) == 1,
              $urandom_range(NS - 1, 0), $urandom_range(BS - 1, 0),
              $urandom_range(255, 0),
              $urandom_range(7, 0) == 0, $urandom_range(17, 0),
              $urandom_range(15, 0) == 0, $urandom_range(19, 0) == 0,
              $urandom_range(1, 0) == 1);
         if (k == 2000) begin
            do_reset();
            idle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
